bcd_display_scan: RTL and testbench
===================================

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clocks per digit-scan slot (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port d_in, input, 4 bits: ones digit, BCD, driven by the upstream decade counter.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of the tens digit.
REQ-006 The block SHALL have port lz_blank, input, 1 bit: leading-zero blank enable for the tens digit.
REQ-007 The block SHALL have port seg, output, 7 bits: segment drive, active-low, bit order gfedcba (seg[0]=a).
REQ-008 The block SHALL have port an, output, 2 bits: anode enables, active-low; an[0]=ones, an[1]=tens.
REQ-009 The block SHALL have port tens, output, 4 bits: current tens digit, BCD.
REQ-010 The block SHALL have port ovf, output, 1 bit: one-cycle pulse on tens wrap 9->0.
REQ-011 The block SHALL have port err, output, 1 bit: sticky flag, d_in seen above 9.

Function
REQ-012 The block SHALL register d_in into d_prev every cycle; d_prev is the displayed ones digit.
REQ-013 The block SHALL detect a ones wrap when d_prev==9 and d_in==0 in the same cycle.
REQ-014 On a ones wrap, the block SHALL increment tens on that edge; at tens==9 it SHALL load 0 and assert ovf for exactly that one cycle.
REQ-015 clr=1 SHALL load tens=0 and take priority over a simultaneous wrap; ovf SHALL stay 0 in that cycle.
REQ-016 Any d_in value of 10..15 SHALL set err=1 one cycle later; err SHALL clear only on reset.
REQ-017 A d_in value of 10..15 SHALL never count as a wrap.
REQ-018 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-019 On the terminal count, sel SHALL toggle (0=ones slot, 1=tens slot).
REQ-020 seg and an SHALL be registered, updating one cycle after sel or the source digit changes.
REQ-021 Latency from d_in to seg, with sel=0 held, SHALL be 2 cycles.
REQ-022 Slot sel=0 SHALL drive an=2'b10 and seg=encode(d_prev).
REQ-023 Slot sel=1 SHALL drive an=2'b01 and seg=encode(tens), except when lz_blank=1 and tens==0, where seg=7'h7F.
REQ-024 Encoding SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex).
REQ-025 A digit value of 10..15 SHALL encode as a dash, 7'h3F.
REQ-026 an SHALL never have both bits 0 in any cycle.

Reset
REQ-027 While rst=0, outputs SHALL be: seg=7'h7F, an=2'b11, tens=0, ovf=0, err=0.
REQ-028 While rst=0, internal state SHALL be: d_prev=0, refresh counter=0, sel=0.
REQ-029 Reset asserted mid-scan SHALL take effect immediately, without waiting for a clock edge.
REQ-030 After rst rises, the first clock edge SHALL drive an=2'b10 and seg=encode(d_prev).

Verification (REFRESH_DIV=4)
REQ-031 Reset release, d_in=0, lz_blank=0 -> an alternates 10/01 every 4 clocks; seg=40 in both slots.
REQ-032 d_in steps 0..9 then 0, one step per clock -> tens goes to 1 one edge after 0 is applied; ovf stays 0.
REQ-033 Ten wraps from tens=9 -> tens=0 and ovf=1 for exactly one cycle.
REQ-034 clr=1 in the same cycle as a wrap -> tens=0 and ovf=0.
REQ-035 d_in=4'hC -> err=1 from the next cycle on; seg=3F in the ones slot; err stays 1 after d_in returns to valid; only rst=0 clears it.
REQ-036 tens=0 with lz_blank=1 -> tens slot shows seg=7F; lz_blank=0 -> tens slot shows seg=40.
REQ-037 rst=0 pulsed mid-slot -> outputs take reset values asynchronously; the scan restarts in slot 0.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Two-digit BCD display scanner: tracks a tens digit from ones-digit wraps,
// multiplexes both digits onto one active-low 7-segment driver.
module bcd_display_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_in,
  input  logic       clr,
  input  logic       lz_blank,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] tens,
  output logic       ovf,
  output logic       err
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  logic [3:0]    d_prev_q;
  logic [3:0]    tens_q, tens_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          wrap;
  logic [3:0]    digit;

  function automatic logic [6:0] enc(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h3F;
    unique case (v)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // A ones wrap needs a real 9 followed by a real 0; invalid codes never match.
  assign wrap = (d_prev_q == 4'd9) && (d_in == 4'd0);

  // Tens digit, overflow pulse and sticky invalid-input flag.
  always_comb begin
    tens_d = tens_q;
    ovf_d  = 1'b0;
    err_d  = err_q | (d_in > 4'd9);
    if (clr) begin
      tens_d = 4'd0;
    end else if (wrap) begin
      if (tens_q == 4'd9) begin
        tens_d = 4'd0;
        ovf_d  = 1'b1;
      end else begin
        tens_d = tens_q + 4'd1;
      end
    end
  end

  // Refresh divider; slot select flips on each terminal count.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    sel_d = sel_q;
    if (cnt_q == TC) begin
      cnt_d = '0;
      sel_d = ~sel_q;
    end
  end

  // Segment/anode pattern for the current slot, blanking a leading zero.
  always_comb begin
    digit = sel_q ? tens_q : d_prev_q;
    an_d  = sel_q ? 2'b01 : 2'b10;
    seg_d = enc(digit);
    if (sel_q && lz_blank && (tens_q == 4'd0)) begin
      seg_d = 7'h7F;
    end
  end

  // All state, cleared asynchronously to a dark display in the ones slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_prev_q <= 4'd0;
      tens_q   <= 4'd0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      seg_q    <= 7'h7F;
      an_q     <= 2'b11;
    end else begin
      d_prev_q <= d_in;
      tens_q   <= tens_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign tens = tens_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV=4.
module tb_bcd_display_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_in;
  logic       clr;
  logic       lz_blank;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] tens;
  logic       ovf;
  logic       err;

  int n_chk = 0;
  int n_err = 0;
  int k = 0;

  bcd_display_scan #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .clr(clr),
    .lz_blank(lz_blank), .seg(seg), .an(an), .tens(tens),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    chk("an_not_00", {31'd0, an == 2'b00}, 32'd0);
  endtask

  task automatic wrap_once();
    d_in = 4'd9;
    tick();
    d_in = 4'd0;
    tick();
  endtask

  initial begin
    rst = 1'b0; d_in = 4'd0; clr = 1'b0; lz_blank = 1'b0;
    tick(); tick();
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 2'b11);
    chk("rst_tens", tens, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);

    // scan alternation, digit 0 in both slots
    rst = 1'b1; k = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("scan_an", an, (((i - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01);
      chk("scan_seg", seg, 7'h40);
    end

    // count 1..9 then 0
    for (int v = 1; v <= 9; v++) begin
      d_in = 4'(v);
      tick();
      chk("cnt_ovf", ovf, 0);
    end
    chk("cnt_tens0", tens, 0);
    d_in = 4'd0;
    tick();
    chk("cnt_tens1", tens, 1);
    chk("cnt_ovf1", ovf, 0);

    // up to 9, then overflow
    repeat (8) wrap_once();
    chk("tens9", tens, 9);
    chk("ovf_pre", ovf, 0);
    wrap_once();
    chk("ovf_tens", tens, 0);
    chk("ovf_set", ovf, 1);
    tick();
    chk("ovf_clear", ovf, 0);
    chk("ovf_hold", tens, 0);

    // clr beats a wrap at tens=9
    repeat (9) wrap_once();
    chk("clr_tens9", tens, 9);
    d_in = 4'd9;
    tick();
    d_in = 4'd0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_tens", tens, 0);
    chk("clr_ovf", ovf, 0);

    // async reset mid-slot
    wrap_once();
    chk("pre_rst_tens", tens, 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_seg", seg, 7'h7F);
    chk("arst_an", an, 2'b11);
    chk("arst_tens", tens, 0);
    tick();
    rst = 1'b1; lz_blank = 1'b1; k = 0;
    tick();
    chk("restart_an", an, 2'b10);
    chk("restart_seg", seg, 7'h40);
    while (k < 5) tick();
    chk("lz_an", an, 2'b01);
    chk("lz_seg", seg, 7'h7F);
    lz_blank = 1'b0;
    tick();
    chk("nolz_seg", seg, 7'h40);
    while (k < 8) tick();

    // ones-slot latency, invalid input, err stickiness
    d_in = 4'd5;
    tick();
    chk("lat1_seg", seg, 7'h40);
    tick();
    chk("lat2_seg", seg, 7'h12);
    chk("err_pre", err, 0);
    d_in = 4'hC;
    tick();
    chk("err_set", err, 1);
    tick();
    chk("dash_an", an, 2'b10);
    chk("dash_seg", seg, 7'h3F);
    d_in = 4'd9;
    tick();
    d_in = 4'd0;
    tick();
    chk("err_sticky", err, 1);
    chk("post_err_tens", tens, 1);
    tick();
    chk("tens_an", an, 2'b01);
    chk("tens_seg", seg, 7'h79);

    #2 rst = 1'b0;
    #1;
    chk("err_rst", err, 0);
    chk("err_rst_an", an, 2'b11);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
